// File: rtl/imm_decode_if.sv
// Handshake bundle for the immediate-decode stage: upstream fetch beat in,
// decoded beat out toward register-read/issue.
interface imm_decode_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_target;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
             out_target, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
             out_target, out_illegal
   );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32/RV64 immediate-decode stage: decodes immediate, format and
// PC-relative target on the input side and carries them with the beat.
module imm_decode_stage #(
   parameter int XLEN    = 32,
   parameter int ZIMM_EN = 1,
   parameter int SKID    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   imm_decode_if.slave  bus
);
   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] tgt;
      logic [2:0]      fmt;
      logic            ill;
   } beat_t;

   // Every legal opcode ends in 2'b11, so the full 7-bit match also rejects
   // compressed-looking encodings.
   function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
      logic [2:0] fmt;
      case (instr[6:0])
         OPC_OP:                        fmt = FMT_R;
         OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
         OPC_STORE:                     fmt = FMT_S;
         OPC_BRANCH:                    fmt = FMT_B;
         OPC_JAL:                       fmt = FMT_J;
         OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
         OPC_SYSTEM:                    fmt = ((ZIMM_EN != 0) && instr[14]) ? FMT_Z : FMT_I;
         default:                       fmt = FMT_ILL;
      endcase
      return fmt;
   endfunction

   function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                        input logic [2:0]  fmt);
      logic signed [11:0]     imm_i;
      logic signed [11:0]     imm_s;
      logic signed [12:0]     imm_b;
      logic signed [20:0]     imm_j;
      logic signed [31:0]     imm_u;
      logic signed [XLEN-1:0] imm;
      imm_i = instr[31:20];
      imm_s = {instr[31:25], instr[11:7]};
      imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      imm_u = {instr[31:12], 12'b0};
      case (fmt)
         FMT_I:   imm = XLEN'(imm_i);
         FMT_S:   imm = XLEN'(imm_s);
         FMT_B:   imm = XLEN'(imm_b);
         FMT_J:   imm = XLEN'(imm_j);
         FMT_U:   imm = XLEN'(imm_u);
         FMT_Z:   imm = XLEN'(instr[19:15]);
         default: imm = '0;
      endcase
      return imm;
   endfunction

   logic [2:0]             fmt_p0;
   logic signed [XLEN-1:0] imm_p0;
   logic                   rel_p0;
   beat_t                  beat_p0;
   beat_t                  main_p1;
   logic                   vld_p1;

   // ---- stage p0: combinational decode of the incoming beat ----
   assign fmt_p0 = decode_fmt(bus.in_instr);
   assign imm_p0 = decode_imm(bus.in_instr, fmt_p0);
   assign rel_p0 = (fmt_p0 == FMT_B) || (fmt_p0 == FMT_J) || (bus.in_instr[6:0] == OPC_AUIPC);

   always_comb begin
      beat_p0       = '0;
      beat_p0.instr = bus.in_instr;
      beat_p0.pc    = bus.in_pc;
      beat_p0.imm   = imm_p0;
      beat_p0.tgt   = rel_p0 ? (bus.in_pc + imm_p0) : (bus.in_pc + XLEN'(4));
      beat_p0.fmt   = fmt_p0;
      beat_p0.ill   = (fmt_p0 == FMT_ILL);
   end

   // ---- stage p1: output register (plus optional skid entry) ----
   if (SKID != 0) begin : g_skid
      beat_t skid_p1;
      logic  skid_vld_p1;
      logic  in_ready_r;
      logic  accept;
      logic  main_free;

      assign accept    = bus.in_valid & in_ready_r & ~flush;
      assign main_free = ~vld_p1 | bus.out_ready;
      assign bus.in_ready = in_ready_r;

      // in_ready_r always tracks !skid_vld_p1 so out_ready never reaches in_ready.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_ready_r  <= 1'b1;
            main_p1     <= '0;
            skid_p1     <= '0;
         end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_ready_r  <= 1'b1;
         end else if (main_free) begin
            if (skid_vld_p1) begin
               main_p1     <= skid_p1;
               vld_p1      <= 1'b1;
               skid_vld_p1 <= accept;
               in_ready_r  <= ~accept;
               if (accept) skid_p1 <= beat_p0;
            end else begin
               vld_p1     <= accept;
               in_ready_r <= 1'b1;
               if (accept) main_p1 <= beat_p0;
            end
         end else if (accept) begin
            skid_p1     <= beat_p0;
            skid_vld_p1 <= 1'b1;
            in_ready_r  <= 1'b0;
         end
      end
   end else begin : g_noskid
      logic in_rdy;
      logic accept;

      assign in_rdy       = ~vld_p1 | bus.out_ready;
      assign accept       = bus.in_valid & in_rdy & ~flush;
      assign bus.in_ready = in_rdy;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p1  <= 1'b0;
            main_p1 <= '0;
         end else if (flush) begin
            vld_p1 <= 1'b0;
         end else if (in_rdy) begin
            vld_p1 <= accept;
            if (accept) main_p1 <= beat_p0;
         end
      end
   end

   assign bus.out_valid   = vld_p1;
   assign bus.out_instr   = main_p1.instr;
   assign bus.out_pc      = main_p1.pc;
   assign bus.out_imm     = main_p1.imm;
   assign bus.out_target  = main_p1.tgt;
   assign bus.out_fmt     = main_p1.fmt;
   assign bus.out_illegal = main_p1.ill;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: an RV32/ZIMM/skid instance and an
// RV64/no-ZIMM/no-skid instance share one randomized stimulus stream.
module tb_imm_decode_stage;
   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [63:0] tgt;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [31:0] imm_a;
      logic [31:0] tgt_a;
      logic [2:0]  fmt_a;
      logic [63:0] imm_b;
      logic [63:0] tgt_b;
      logic [2:0]  fmt_b;
   } dir_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [63:0] in_pc = '0;
   logic        out_ready = 1'b0;
   int          dir_idx = -1;

   int checks = 0;
   int errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   dir_t tab[12];

   imm_decode_if #(.XLEN(32)) bus_a ();
   imm_decode_if #(.XLEN(64)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_instr  = in_instr;
   assign bus_a.in_pc     = in_pc[31:0];
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_instr  = in_instr;
   assign bus_b.in_pc     = in_pc;
   assign bus_b.out_ready = out_ready;

   imm_decode_stage #(.XLEN(32), .ZIMM_EN(1), .SKID(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a.slave));
   imm_decode_stage #(.XLEN(64), .ZIMM_EN(0), .SKID(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic longint sx(input logic [31:0] v, input int bits);
      longint x;
      x = longint'(v);
      if (v[bits-1]) x = x - (longint'(1) << bits);
      return x;
   endfunction

   // Reference decode straight from the opcode table, with integer arithmetic.
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc_in,
                                  input int xlen, input bit zimm);
      exp_t        e;
      longint      imm;
      logic [63:0] mask;
      bit          rel;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      imm = 0;
      rel = 0;
      e = '0;
      e.fmt = 3'd7;
      case (ins[6:0])
         7'b0110011: e.fmt = 3'd0;
         7'b0010011, 7'b0000011, 7'b1100111: begin e.fmt = 3'd1; imm = sx(32'(ins[31:20]), 12); end
         7'b0100011: begin e.fmt = 3'd2; imm = sx(32'({ins[31:25], ins[11:7]}), 12); end
         7'b1100011: begin
            e.fmt = 3'd3; rel = 1;
            imm = sx(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
         end
         7'b1101111: begin
            e.fmt = 3'd5; rel = 1;
            imm = sx(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
         end
         7'b0110111: begin e.fmt = 3'd4; imm = sx({ins[31:12], 12'b0}, 32); end
         7'b0010111: begin e.fmt = 3'd4; rel = 1; imm = sx({ins[31:12], 12'b0}, 32); end
         7'b1110011: begin
            if (zimm && ins[14]) begin e.fmt = 3'd6; imm = longint'(ins[19:15]); end
            else begin e.fmt = 3'd1; imm = sx(32'(ins[31:20]), 12); end
         end
         default: e.fmt = 3'd7;
      endcase
      e.instr = ins;
      e.pc    = pc_in & mask;
      e.imm   = 64'(imm) & mask;
      e.tgt   = (rel ? (e.pc + 64'(imm)) : (e.pc + 64'd4)) & mask;
      e.ill   = (e.fmt == 3'd7);
      return e;
   endfunction

   // Monitor: state checks against queue occupancy, head compare, then the
   // pop/push implied by the handshake at the coming edge.
   always @(negedge clk) begin
      exp_t ea, eb;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
      end else begin
         chk("a_out_valid", 64'(bus_a.out_valid), 64'(qa.size() != 0));
         chk("a_in_ready", 64'(bus_a.in_ready), 64'(qa.size() < 2));
         chk("b_out_valid", 64'(bus_b.out_valid), 64'(qb.size() != 0));
         chk("b_in_ready", 64'(bus_b.in_ready), 64'((qb.size() == 0) || out_ready));
         if (bus_a.out_valid && qa.size() != 0) begin
            ea = qa[0];
            chk("a_instr", 64'(bus_a.out_instr), 64'(ea.instr));
            chk("a_pc", 64'(bus_a.out_pc), ea.pc);
            chk("a_imm", 64'(bus_a.out_imm), ea.imm);
            chk("a_target", 64'(bus_a.out_target), ea.tgt);
            chk("a_fmt", 64'(bus_a.out_fmt), 64'(ea.fmt));
            chk("a_illegal", 64'(bus_a.out_illegal), 64'(ea.ill));
         end
         if (bus_b.out_valid && qb.size() != 0) begin
            eb = qb[0];
            chk("b_instr", 64'(bus_b.out_instr), 64'(eb.instr));
            chk("b_pc", bus_b.out_pc, eb.pc);
            chk("b_imm", bus_b.out_imm, eb.imm);
            chk("b_target", bus_b.out_target, eb.tgt);
            chk("b_fmt", 64'(bus_b.out_fmt), 64'(eb.fmt));
            chk("b_illegal", 64'(bus_b.out_illegal), 64'(eb.ill));
         end
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (bus_a.out_valid && out_ready && qa.size() != 0) void'(qa.pop_front());
            if (bus_b.out_valid && out_ready && qb.size() != 0) void'(qb.pop_front());
            if (dir_idx >= 0) begin
               ea = '{tab[dir_idx].instr, {32'b0, tab[dir_idx].pc[31:0]},
                      {32'b0, tab[dir_idx].imm_a}, {32'b0, tab[dir_idx].tgt_a},
                      tab[dir_idx].fmt_a, tab[dir_idx].fmt_a == 3'd7};
               eb = '{tab[dir_idx].instr, tab[dir_idx].pc, tab[dir_idx].imm_b,
                      tab[dir_idx].tgt_b, tab[dir_idx].fmt_b, tab[dir_idx].fmt_b == 3'd7};
            end else begin
               ea = model(in_instr, in_pc, 32, 1'b1);
               eb = model(in_instr, in_pc, 64, 1'b0);
            end
            if (in_valid && bus_a.in_ready) qa.push_back(ea);
            if (in_valid && bus_b.in_ready) qb.push_back(eb);
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl, input int idx);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      dir_idx   = idx;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  opc [10];
      opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};
      r = $urandom();
      if ($urandom_range(7) != 0) r[6:0] = opc[$urandom_range(9)];
      return r;
   endfunction

   task automatic random_run(input int n);
      logic [63:0] pc;
      for (int i = 0; i < n; i++) begin
         pc = {$urandom(), $urandom()};
         drive(1'($urandom_range(3) != 0), rand_instr(), pc,
               1'($urandom_range(3) != 0), 1'($urandom_range(39) == 0), -1);
      end
   endtask

   initial begin
      tab[0]  = '{32'hFFF00093, 64'h100, 32'hFFFFFFFF, 32'h104, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'h104, 3'd1};
      tab[1]  = '{32'hFE000CE3, 64'h200, 32'hFFFFFFF8, 32'h1F8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'h1F8, 3'd3};
      tab[2]  = '{32'h123452B7, 64'h300, 32'h12345000, 32'h304, 3'd4, 64'h0000000012345000, 64'h304, 3'd4};
      tab[3]  = '{32'h800002B7, 64'h304, 32'h80000000, 32'h308, 3'd4, 64'hFFFFFFFF80000000, 64'h308, 3'd4};
      tab[4]  = '{32'h300FD073, 64'h400, 32'h0000001F, 32'h404, 3'd6, 64'h300, 64'h404, 3'd1};
      tab[5]  = '{32'h00000000, 64'h500, 32'h0, 32'h504, 3'd7, 64'h0, 64'h504, 3'd7};
      tab[6]  = '{32'h0080006F, 64'h600, 32'h8, 32'h608, 3'd5, 64'h8, 64'h608, 3'd5};
      tab[7]  = '{32'hFFFFF017, 64'h10, 32'hFFFFF000, 32'hFFFFF010, 3'd4, 64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFF010, 3'd4};
      tab[8]  = '{32'hFE112E23, 64'h700, 32'hFFFFFFFC, 32'h704, 3'd2, 64'hFFFFFFFFFFFFFFFC, 64'h704, 3'd2};
      tab[9]  = '{32'h002081B3, 64'h800, 32'h0, 32'h804, 3'd0, 64'h0, 64'h804, 3'd0};
      tab[10] = '{32'h0100006F, 64'hFFFFFFF0, 32'h10, 32'h0, 3'd5, 64'h10, 64'h100000000, 3'd5};
      tab[11] = '{32'h00000090, 64'h900, 32'h0, 32'h904, 3'd7, 64'h0, 64'h904, 3'd7};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
      chk("rst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
      chk("rst_a_imm", 64'(bus_a.out_imm), 64'd0);
      chk("rst_a_target", 64'(bus_a.out_target), 64'd0);
      chk("rst_a_fmt", 64'(bus_a.out_fmt), 64'd0);
      chk("rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
      chk("rst_b_instr", 64'(bus_b.out_instr), 64'd0);
      chk("rst_b_pc", bus_b.out_pc, 64'd0);
      chk("rst_b_illegal", 64'(bus_b.out_illegal), 64'd0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) drive(1'b1, tab[i].instr, tab[i].pc, 1'b1, 1'b0, i);
      drive(1'b0, '0, '0, 1'b1, 1'b0, -1);

      // Stall with three beats offered, then release.
      for (int i = 0; i < 3; i++) drive(1'b1, rand_instr(), 64'h1000 + 64'(4 * i), 1'b0, 1'b0, -1);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, -1);

      // Fill both entries, flush with a beat offered, then an all-zero word.
      for (int i = 0; i < 2; i++) drive(1'b1, rand_instr(), 64'h2000 + 64'(4 * i), 1'b0, 1'b0, -1);
      drive(1'b1, rand_instr(), 64'h3000, 1'b0, 1'b1, -1);
      drive(1'b1, tab[5].instr, tab[5].pc, 1'b1, 1'b0, 5);
      drive(1'b0, '0, '0, 1'b1, 1'b0, -1);

      random_run(800);

      // Asynchronous reset in the middle of traffic.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
      chk("midrst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
      chk("midrst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      random_run(800);

      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, -1);
      @(posedge clk);
      #1;
      chk("drain_a_left", 64'(qa.size()), 64'd0);
      chk("drain_b_left", 64'(qb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode stage for the RV32/RV64 front end, placed between fetch and the register-read/issue stage. Each accepted instruction produces:
- an XLEN-wide sign/zero-extended immediate;
- a format code and an illegal-opcode flag;
- a precomputed PC-relative target.

Handshake is valid/ready on both sides with optional skid buffering and a synchronous flush for redirects.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ZIMM_EN, 1, 1 = decode CSR-immediate (zimm) form of SYSTEM; 0 = SYSTEM always I-format.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 illegal.
- out_target  out  XLEN  computed target address.
- out_illegal  out  1  unrecognised opcode.

## Operation
- Opcode map (instr[6:0]) and resulting format:
  - OP 0110011 → R, imm 0.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 → I: sext(instr[31:20]).
  - STORE 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - JAL 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - LUI 0110111, AUIPC 0010111 → U: sext({instr[31:12], 12'b0}).
  - SYSTEM 1110011:
    - ZIMM_EN=1 and instr[14]=1 → Z: zero-extend instr[19:15].
    - Otherwise → I.
- Extension rule: all sext is taken from instr[31] to full XLEN. For XLEN=64, U-format bits 63:32 replicate instr[31].
- Any other opcode, or instr[1:0]≠2'b11:
  - out_fmt=7, out_illegal=1, out_imm=0.
  - The beat still flows through; it is not dropped.
- Target: out_target = pc+imm for B, J and AUIPC; pc+4 for everything else. Addition is modulo 2^XLEN; wrap is silent.
- Decode and add are performed on the input side; results are registered with the beat.
- SKID=1:
  - Holds a main output register plus one skid entry.
  - in_ready is a register equal to !skid_valid.
  - A beat arriving while the main register is stalled goes to skid.
  - When main drains, skid moves to main.
- SKID=0:
  - in_ready = !out_valid | out_ready.
- Ordering is strictly FIFO; no beat is duplicated or lost.
- Flush:
  - At the next edge, out_valid=0 and the skid entry is emptied.
  - A beat presented in the flush cycle is discarded.
  - in_ready reads 1 in the cycle after the flush.
- Flush overrides simultaneous acceptance and drain.

## Timing
- Latency: exactly 1 cycle from in_valid&in_ready to out_valid.
- Throughput: 1 beat/cycle with out_ready held high, in both modes.
- A transfer occurs on an edge where valid&ready.
- While out_valid=1 and out_ready=0, all out_* signals are held stable.
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid=0, skid empty, in_ready=1.
  - out_instr, out_pc, out_imm, out_target = 0; out_fmt=0; out_illegal=0.
- Reset mid-stream drops all held beats with no partial output.
- Boundary, SKID=1: when both entries are full, in_ready is 0 the following cycle. Simultaneous drain and accept with skid empty keeps the skid empty.
- Boundary, SKID=0: simultaneous accept and drain replaces the main register in the same edge.
- No combinational path from out_ready to in_ready when SKID=1.

## Test plan
- ADDI 0xFFF00093, pc 0x100 → one cycle later: out_imm 0xFFFFFFFF, fmt 1, target 0x104.
- BEQ 0xFE000CE3, pc 0x200 → out_imm 0xFFFFFFF8, fmt 3, target 0x000001F8.
- XLEN=64: LUI 0x123452B7 → out_imm 0x0000000012345000. LUI 0x800002B7 → out_imm 0xFFFFFFFF80000000, fmt 4.
- CSRRWI 0x300FD073:
  - ZIMM_EN=1 → out_imm 0x1F, fmt 6.
  - ZIMM_EN=0 → out_imm 0x300, fmt 1.
- SKID=1, out_ready low for 3 cycles while 3 beats are offered:
  - First two are accepted; in_ready falls.
  - Release out_ready → beats emerge in order, one per cycle, with no loss.
- Flush with both entries full → out_valid 0 next cycle. Then 0x00000000 → out_illegal 1, fmt 7, imm 0, target pc+4.
